// File: rtl/oam_dma_ctrl_if.sv
// Shared-bus bundle between the CPU/memory side and the sprite DMA controller.
// The controller takes the slave modport; the CPU core plus memory fabric take master.
interface oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic        dma_busy;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        input  cpu_rdy, cpu_rdata, mem_addr, mem_wdata, mem_oe_n, mem_we_n, dma_busy
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
        output cpu_rdy, cpu_rdata, mem_addr, mem_wdata, mem_oe_n, mem_we_n, dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a CPU write to the page register stalls the CPU and
// copies one page of memory into the PPU OAM data port as read/write pairs.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic            clk,
    input  logic            rst,
    oam_dma_ctrl_if.slave   bus
);
    localparam int IDX_W = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       page, page_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [7:0]       data_buf, data_buf_nxt;
    logic             cyc_odd;
    logic [7:0]       idx_lo;

    assign idx_lo        = 8'(idx);
    assign bus.cpu_rdata = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= '0;
            data_buf <= 8'h00;
        end else begin
            state    <= state_nxt;
            page     <= page_nxt;
            idx      <= idx_nxt;
            data_buf <= data_buf_nxt;
        end
    end

    // Free-running phase bit; DMA reads must land on the even phase, hence ALIGN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_odd <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
        end
    end

    always_comb begin
        state_nxt     = state;
        page_nxt      = page;
        idx_nxt       = idx;
        data_buf_nxt  = data_buf;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = data_buf;
        bus.mem_oe_n  = 1'b1;
        bus.mem_we_n  = 1'b1;
        bus.cpu_rdy   = 1'b0;
        bus.dma_busy  = 1'b1;

        case (state)
            IDLE: begin
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_oe_n  = bus.cpu_we;
                bus.mem_we_n  = ~bus.cpu_we;
                bus.cpu_rdy   = 1'b1;
                bus.dma_busy  = 1'b0;
                if (bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR)) begin
                    page_nxt  = bus.cpu_wdata;
                    idx_nxt   = '0;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = cyc_odd ? ALIGN : READ;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                bus.mem_addr = {page, idx_lo};
                bus.mem_oe_n = 1'b0;
                data_buf_nxt = bus.mem_rdata;
                state_nxt    = WRITE;
            end
            WRITE: begin
                bus.mem_addr = OAM_DATA_ADDR;
                bus.mem_we_n = 1'b0;
                if (idx == IDX_LAST) begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory byte = addr[7:0]^A5, a negedge monitor
// tallies DMA traffic and the main sequence asserts on the tallies.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst;

    oam_dma_ctrl_if bus();

    oam_dma_ctrl #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004),
        .XFER_LEN     (256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_addr[7:0] ^ 8'hA5;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    int          rd_cnt, wr_cnt, stall_cnt, pre_cnt, seq_err, zero_hit;
    int          wr_total = 0;
    int          pt_err = 0;
    int          overlap = 0;
    logic        exp_read;
    logic [7:0]  cur_page;
    logic [15:0] first_rd, last_rd;
    logic [7:0]  first_wd, last_wd;

    // Parity model of the controller's free-running phase bit.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt = 0;
        else     edge_cnt = edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.mem_oe_n && !bus.mem_we_n) overlap++;
            if (bus.cpu_rdy === 1'b0) stall_cnt++;
            if (bus.dma_busy !== ~bus.cpu_rdy) seq_err++;
            if (bus.dma_busy === 1'b0) begin
                if (bus.mem_addr !== bus.cpu_addr || bus.mem_oe_n !== bus.cpu_we ||
                    bus.mem_we_n !== ~bus.cpu_we ||
                    (bus.cpu_we && bus.mem_wdata !== bus.cpu_wdata))
                    pt_err++;
            end else if (!bus.mem_oe_n) begin
                if (!exp_read) seq_err++;
                if (bus.mem_addr !== {cur_page, 8'(rd_cnt)}) seq_err++;
                if (bus.mem_addr === 16'h0000) zero_hit++;
                if (rd_cnt == 0) first_rd = bus.mem_addr;
                last_rd = bus.mem_addr;
                rd_cnt++;
                exp_read = 1'b0;
            end else if (!bus.mem_we_n) begin
                if (exp_read) seq_err++;
                if (bus.mem_addr !== 16'h2004) seq_err++;
                if (bus.mem_wdata !== (8'(wr_cnt) ^ 8'hA5)) seq_err++;
                if (wr_cnt == 0) first_wd = bus.mem_wdata;
                last_wd = bus.mem_wdata;
                wr_cnt++;
                wr_total++;
                exp_read = 1'b1;
            end else begin
                if (rd_cnt != 0 || wr_cnt != 0) seq_err++;
                pre_cnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] wdata,
                                 input logic we);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_we    = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats(input logic [7:0] page);
        rd_cnt = 0; wr_cnt = 0; stall_cnt = 0; pre_cnt = 0; seq_err = 0; zero_hit = 0;
        exp_read = 1'b1;
        cur_page = page;
        first_rd = 16'hxxxx; last_rd = 16'hxxxx;
        first_wd = 8'hxx; last_wd = 8'hxx;
    endtask

    // Called at #1 after a posedge; want_par<0 triggers in the current cycle.
    task automatic runDma(input string tag, input logic [7:0] page, input int want_par);
        int  trig_par;
        int  exp_stall;
        int  exp_pre;
        bit  done;
        if (want_par >= 0 && (edge_cnt % 2) != want_par) step();
        trig_par  = edge_cnt % 2;
        exp_stall = (trig_par == 0) ? 514 : 513;
        exp_pre   = (trig_par == 0) ? 2 : 1;
        clearStats(page);
        applyStimulus(16'h4014, page, 1'b1);
        step();
        applyStimulus(16'h4014, 8'h55, 1'b1);
        repeat (8) step();
        applyStimulus(16'h8000, 8'h00, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 700 && !done; i++) begin
            if (bus.cpu_rdy === 1'b1) done = 1'b1;
            else step();
        end
        checkOutput({tag, "_done"},     32'(done),      32'd1);
        checkOutput({tag, "_stall"},    stall_cnt,      exp_stall);
        checkOutput({tag, "_pre"},      pre_cnt,        exp_pre);
        checkOutput({tag, "_reads"},    rd_cnt,         32'd256);
        checkOutput({tag, "_writes"},   wr_cnt,         32'd256);
        checkOutput({tag, "_seq"},      seq_err,        32'd0);
        checkOutput({tag, "_first_rd"}, 32'(first_rd),  32'({page, 8'h00}));
        checkOutput({tag, "_last_rd"},  32'(last_rd),   32'({page, 8'hFF}));
        checkOutput({tag, "_first_wd"}, 32'(first_wd),  32'h0A5);
        checkOutput({tag, "_last_wd"},  32'(last_wd),   32'h05A);
        checkOutput({tag, "_busy"},     32'(bus.dma_busy), 32'd0);
    endtask

    initial begin
        int   base;
        bit   found;
        rst = 1'b1;
        applyStimulus(16'h0000, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rdy",  32'(bus.cpu_rdy),  32'd1);
        checkOutput("rst_busy", 32'(bus.dma_busy), 32'd0);
        checkOutput("rst_oe",   32'(bus.mem_oe_n), 32'd0);
        checkOutput("rst_we",   32'(bus.mem_we_n), 32'd1);
        rst = 1'b0;
        step();

        $display("[TB] passthrough, non-trigger accesses");
        applyStimulus(16'h4015, 8'h3C, 1'b1);
        #2;
        checkOutput("pt1_addr", 32'(bus.mem_addr),  32'h4015);
        checkOutput("pt1_wd",   32'(bus.mem_wdata), 32'h3C);
        checkOutput("pt1_we",   32'(bus.mem_we_n),  32'd0);
        checkOutput("pt1_oe",   32'(bus.mem_oe_n),  32'd1);
        step();
        applyStimulus(16'h2004, 8'h77, 1'b1);
        #2;
        checkOutput("pt2_addr", 32'(bus.mem_addr),  32'h2004);
        checkOutput("pt2_busy", 32'(bus.dma_busy),  32'd0);
        step();
        applyStimulus(16'h4014, 8'h09, 1'b0);
        #2;
        checkOutput("pt3_oe",    32'(bus.mem_oe_n),  32'd0);
        checkOutput("pt3_we",    32'(bus.mem_we_n),  32'd1);
        checkOutput("pt3_rdata", 32'(bus.cpu_rdata), 32'hB1);
        step();
        applyStimulus(16'h8000, 8'h00, 1'b0);
        #2;
        checkOutput("pt4_rdy",  32'(bus.cpu_rdy),  32'd1);
        checkOutput("pt4_busy", 32'(bus.dma_busy), 32'd0);
        step();

        $display("[TB] even alignment");
        runDma("even", 8'h02, 1);
        checkOutput("even_stall513", stall_cnt, 32'd513);
        step();

        $display("[TB] odd alignment");
        runDma("odd", 8'h02, 0);
        checkOutput("odd_stall514", stall_cnt, 32'd514);
        step();

        $display("[TB] page wrap then back-to-back");
        base = wr_total;
        runDma("wrap", 8'hFF, 1);
        checkOutput("wrap_zero", zero_hit, 32'd0);
        runDma("b2b", 8'h04, -1);
        checkOutput("b2b_total", wr_total - base, 32'd512);
        step();

        $display("[TB] reset mid-transfer");
        clearStats(8'h01);
        applyStimulus(16'h4014, 8'h01, 1'b1);
        step();
        applyStimulus(16'h8000, 8'h00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (!bus.mem_oe_n && bus.dma_busy && bus.mem_addr === 16'h0140) found = 1'b1;
            else step();
        end
        checkOutput("mid_found", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rdy",  32'(bus.cpu_rdy),  32'd1);
        checkOutput("mid_busy", 32'(bus.dma_busy), 32'd0);
        checkOutput("mid_we",   32'(bus.mem_we_n), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mid_wr_cnt", wr_cnt, 32'd64);
        checkOutput("mid_rd_cnt", rd_cnt, 32'd64);
        rst = 1'b0;
        step();
        checkOutput("post_rst_busy", 32'(bus.dma_busy), 32'd0);
        runDma("after_rst", 8'h03, -1);
        step();

        checkOutput("passthrough_err", pt_err,  32'd0);
        checkOutput("strobe_overlap",  overlap, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA controller and bus arbiter for the 6502 system bus.
- A CPU write to the DMA page register stalls the CPU through RDY and takes ownership of the shared memory bus (ROM/RAM/PPU decode).
- It then copies 256 bytes from page P (P*256 .. P*256+255) to the PPU OAM data port as alternating read/write cycles.
- Sits between the CPU core and the memory/address-decode fabric.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA; data byte = source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write cycle.
- XFER_LEN, 256, bytes per transfer; power of two, 2..256.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_addr  input  16  CPU address bus.
- cpu_wdata  input  8  CPU write data.
- cpu_we  input  1  1 = CPU write cycle, 0 = read cycle.
- cpu_rdy  output  1  1 = CPU may advance; 0 = CPU stalled.
- cpu_rdata  output  8  read data to CPU; equals mem_rdata.
- mem_addr  output  16  shared bus address.
- mem_wdata  output  8  shared bus write data.
- mem_rdata  input  8  shared bus read data; combinational from addr/oe_n.
- mem_oe_n  output  1  active-low output enable.
- mem_we_n  output  1  active-low write strobe.
- dma_busy  output  1  1 while the controller owns the bus.

Behaviour:
- State machine: IDLE, HALT, ALIGN, READ, WRITE. Registers: state, page[7:0], idx[log2(XFER_LEN)-1:0], buf[7:0], cyc_odd.
- Reset (async): state=IDLE, page=0, idx=0, buf=0, cyc_odd=0.
- Outputs on reset: cpu_rdy=1, dma_busy=0, bus in CPU passthrough.
- cyc_odd toggles every clock, free-running from reset; it is never cleared by DMA.
- IDLE (CPU passthrough, combinational):
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_oe_n=cpu_we, mem_we_n=~cpu_we.
  - cpu_rdy=1, dma_busy=0.
  - If cpu_we=1 and cpu_addr==DMA_REG_ADDR: page<=cpu_wdata, idx<=0, next=HALT.
  - The trigger write is also forwarded to the bus.
- HALT (1 cycle): cpu_rdy=0, dma_busy=1, mem_oe_n=1, mem_we_n=1, mem_addr=cpu_addr.
  - cyc_odd==1 in this cycle -> ALIGN; else -> READ.
- ALIGN (1 cycle): same outputs as HALT; -> READ.
- READ: mem_addr={page, idx} (low 8 bits = idx, zero-extended when XFER_LEN<256), mem_oe_n=0, mem_we_n=1.
  - buf<=mem_rdata at the closing edge; -> WRITE.
- WRITE: mem_addr=OAM_DATA_ADDR, mem_wdata=buf, mem_oe_n=1, mem_we_n=0.
  - If idx==XFER_LEN-1: idx<=0, -> IDLE. Else idx<=idx+1, -> READ.
- cpu_rdy=0 and dma_busy=1 in every non-IDLE state.
- Latency: trigger cycle T; cpu_rdy low from T+1.
  - Total stall = 1+2*XFER_LEN cycles (513 at default) when cyc_odd=0 in HALT; 2+2*XFER_LEN (514) when 1.
  - cpu_rdy returns to 1 in the cycle after the final WRITE.
- Boundaries:
  - CPU inputs are ignored while busy; no retrigger mid-transfer.
  - Trigger in the first IDLE cycle after completion is accepted normally.
  - Page 0xFF reads 0xFF00..0xFFFF; idx wraps to 0 without carry into page.
  - Reset mid-transfer aborts immediately: no further mem_we_n pulse, cpu_rdy=1 asynchronously, OAM left partially written.
- mem_we_n and mem_oe_n are never 0 simultaneously.

Test Plan:
- Trigger, even alignment: write 8'h02 to 16'h4014 with cyc_odd=1 at trigger (0 in HALT), memory byte = addr[7:0]^8'hA5. Required: cpu_rdy low exactly 513 cycles; 256 reads 0x0200..0x02FF; 256 writes to 0x2004 with data 0xA5,0xA4,...; reads and writes strictly alternate.
- Trigger, odd alignment: same stimulus delayed one cycle. Required: 514-cycle stall; one extra ALIGN cycle with both strobes high before the first READ.
- Non-trigger writes: CPU writes 16'h4015 and 16'h2004, and reads 16'h4014. Required: cpu_rdy stays 1, dma_busy 0, bus passthrough matches CPU every cycle.
- Page wrap: trigger with page 8'hFF. Required: last read address 0xFFFF; next state IDLE; no access to 0x0000.
- Reset mid-transfer: assert rst during the READ of idx 0x40. Required: same cycle gives cpu_rdy=1, dma_busy=0, mem_we_n=1. After release, state IDLE; a new trigger with page 0x03 performs a full clean transfer starting at 0x0300.
- Back-to-back: re-trigger with page 0x04 in the first IDLE cycle after a completed DMA. Required: second transfer starts; total of 512 OAM writes observed; stall counts as per the alignment rule.
